seg7_scan_decoder: RTL
======================

Name: seg7_scan_decoder

Overview:
- Inverse of the team's BCD-to-7-segment encoder. Monitors a time-multiplexed 8-bit segment bus plus a one-hot digit strobe, and recovers the 3-bit-range BCD value of each display digit.
- Each sample must pass a stability filter before it is captured.
- Assembles captured digits into a frame and presents it on a valid/ready interface.
- Used as a display-loopback checker and for self-test of the scan driver.

Parameters:
- NDIG, 4, number of scanned digits (1..8); width of dig_sel and number of nibbles in frame_data.
- STABLE_CYC, 3, consecutive identical cycles required before a sample is captured (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- seg_in  in  8  segment bus; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp; 1 = lit.
- dig_sel  in  NDIG  one-hot digit strobe; all-zero = blanking interval.
- frame_data  out  4*NDIG  decoded digits; nibble i = digit i.
- frame_err  out  NDIG  per-digit flag: pattern not decodable.
- frame_valid  out  1  frame_data/frame_err hold a complete frame.
- frame_ready  in  1  consumer accepts the frame when high together with frame_valid.
- overrun  out  1  sticky; a frame completed while the previous one was not yet accepted.

Behaviour:
- Reset: all registers clear asynchronously. frame_data=0, frame_err=0, frame_valid=0, overrun=0, FSM in IDLE, stability counter 0.
- Decode table on seg_in[7:1]; dp is ignored unless the optional feature is enabled:
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7.
  - 1111111 -> 4'hF, the encoder's out-of-range indication; not an error.
  - Any other pattern -> nibble 4'hE, err bit set.
- Stability filter:
  - Registers {dig_sel, seg_in} each cycle.
  - The counter increments while the current input equals the previous cycle's input and dig_sel is exactly one-hot. It resets to 0 on any change.
  - When the counter reaches STABLE_CYC-1, the sample is captured once. No further capture occurs until the input changes.
- Not one-hot dig_sel (zero or multi-hot): no capture; the counter is held at 0.
- FSM:
  - IDLE: wait for a capture of digit 0 -> COLLECT.
  - COLLECT: store each captured digit into a shadow register and set its seen bit. A recapture of an already-seen digit overwrites it.
  - When all NDIG seen bits are set, go to PRESENT on the next cycle: copy shadow -> frame outputs, set frame_valid, clear the seen bits, return to COLLECT.
  - In COLLECT, a capture of digit 0 while the seen bits are partially set restarts the frame: seen bits are cleared, then digit 0 is stored.
- Handshake:
  - frame_valid rises the cycle after the last digit is captured (latency = capture cycle + 1).
  - frame_valid stays high and frame_data/frame_err stay stable until a cycle with frame_ready=1.
  - frame_valid falls the following cycle unless a new frame is presented in that same cycle. In that case frame_valid stays 1 with the new data (back-to-back).
- Overrun: a new frame that completes while frame_valid=1 and frame_ready=0 is dropped and overrun is set. overrun clears only on rst.
- Reset mid-frame: the partial frame is discarded; there is no output activity until a fresh digit-0 capture.

Optional Feature:
- Macro SEG7_DP_CHECK_EN.
- Defined: the dp bit is also checked, matching encoder output. Digit code 0 requires dp=1; codes 1..7 require dp=0; 1111111 requires dp=1. A mismatch sets that digit's frame_err bit; the nibble is still the decoded value.
- Undefined: dp is ignored entirely and no dp logic is synthesized.

Test Plan:
- Reset: assert rst mid-scan -> all outputs 0 asynchronously; after release, the first frame appears only after a full 0..NDIG-1 scan.
- Normal scan, NDIG=4, STABLE_CYC=3: digits 3,1,7,0 each held 5 cycles, frame_ready=1 -> frame_data=16'h0713, frame_err=0, frame_valid high exactly 1 cycle, one cycle after digit-3 capture.
- Glitch filter: seg_in toggles every cycle on digit 1 for 2 cycles then settles on 0110011 -> exactly one capture, nibble 1 = 4, no error.
- Bad pattern and all-on: digit 2 = 8'b00000001, digit 3 = 8'b11111111 -> nibble2=E with frame_err[2]=1; nibble3=F with frame_err[3]=0.
- Backpressure: frame_ready=0 across two complete scans -> first frame held stable, second dropped, overrun=1; frame_ready=1 -> valid drops the next cycle.
- SEG7_DP_CHECK_EN: digit 0 sent as 8'b11111100 -> nibble 0, frame_err[0]=1; without the macro -> frame_err[0]=0.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// ============================================================================
// Module   : seg7_scan_decoder
// Purpose  : Recovers BCD digits from a scanned 7-segment bus and presents
//            them as valid/ready frames. Define SEG7_DP_CHECK_EN to check dp.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_decoder #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        seg_in,
  input  logic [NDIG-1:0]   dig_sel,
  output logic [4*NDIG-1:0] frame_data,
  output logic [NDIG-1:0]   frame_err,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              overrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  localparam logic [3:0]      c_cap_lvl = 4'(STABLE_CYC - 1);
  localparam logic [3:0]      c_sat     = 4'(STABLE_CYC);
  localparam logic [NDIG-1:0] c_one     = NDIG'(1);

  // Returns {err, nibble} for the seven segment lines a..g.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] res;
    res = {1'b1, 4'hE};
    case (pat)
      7'b1111110: res = {1'b0, 4'h0};
      7'b0110000: res = {1'b0, 4'h1};
      7'b1101101: res = {1'b0, 4'h2};
      7'b1111001: res = {1'b0, 4'h3};
      7'b0110011: res = {1'b0, 4'h4};
      7'b1011011: res = {1'b0, 4'h5};
      7'b1011111: res = {1'b0, 4'h6};
      7'b1110000: res = {1'b0, 4'h7};
      7'b1111111: res = {1'b0, 4'hF};
      default:    res = {1'b1, 4'hE};
    endcase
    return res;
  endfunction

  state_t              r_state, w_state_nxt;
  logic [NDIG-1:0]     r_prev_sel;
  logic [7:0]          r_prev_seg;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic [4*NDIG-1:0]   r_shadow, w_shadow_nxt;
  logic [NDIG-1:0]     r_shadow_err, w_shadow_err_nxt;
  logic [NDIG-1:0]     r_seen, w_seen_nxt;
  logic [4*NDIG-1:0]   r_frame_data;
  logic [NDIG-1:0]     r_frame_err;
  logic                r_frame_valid, r_overrun;
  logic                w_onehot, w_same, w_cap, w_take, w_present;
  logic [3:0]          w_dec_nib;
  logic                w_dec_err, w_dig_err;

  assign w_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - c_one)) == '0);
  assign w_same   = (dig_sel == r_prev_sel) && (seg_in == r_prev_seg);
  assign {w_dec_err, w_dec_nib} = decode(seg_in[7:1]);

`ifdef SEG7_DP_CHECK_EN
  // Encoder lights dp only for code 0 and the all-on indication.
  logic w_dp_exp;
  assign w_dp_exp  = (seg_in[7:1] == 7'b1111110) || (seg_in[7:1] == 7'b1111111);
  assign w_dig_err = w_dec_err || (seg_in[0] != w_dp_exp);
`else
  assign w_dig_err = w_dec_err;
`endif

  // Counter saturates past the capture level so a held sample fires once.
  always_comb begin
    w_cnt_nxt = '0;
    if (w_onehot && w_same)
      w_cnt_nxt = (r_cnt == c_sat) ? r_cnt : r_cnt + 4'd1;
  end

  assign w_cap = w_onehot && (w_cnt_nxt == c_cap_lvl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_sel <= '0;
      r_prev_seg <= '0;
      r_cnt      <= '0;
    end else begin
      r_prev_sel <= dig_sel;
      r_prev_seg <= seg_in;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_shadow_nxt     = r_shadow;
    w_shadow_err_nxt = r_shadow_err;
    w_seen_nxt       = r_seen;
    w_take           = 1'b0;
    w_present        = 1'b0;
    case (r_state)
      ST_IDLE:    w_take = w_cap && dig_sel[0];
      ST_COLLECT: w_take = w_cap;
      ST_PRESENT: begin
        w_take      = w_cap;
        w_state_nxt = ST_COLLECT;
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
    if (w_take) begin
      for (int i = 0; i < NDIG; i++) begin
        if (dig_sel[i]) begin
          w_shadow_nxt[4*i +: 4] = w_dec_nib;
          w_shadow_err_nxt[i]    = w_dig_err;
        end
      end
      // Digit 0 always opens a new frame, discarding any partial one.
      w_seen_nxt  = dig_sel[0] ? c_one : (r_seen | dig_sel);
      w_state_nxt = ST_COLLECT;
      if (w_seen_nxt == '1) begin
        w_present   = 1'b1;
        w_seen_nxt  = '0;
        w_state_nxt = ST_PRESENT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow      <= '0;
      r_shadow_err  <= '0;
      r_seen        <= '0;
      r_frame_data  <= '0;
      r_frame_err   <= '0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_shadow     <= w_shadow_nxt;
      r_shadow_err <= w_shadow_err_nxt;
      r_seen       <= w_seen_nxt;
      if (w_present) begin
        if (r_frame_valid && !frame_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_frame_data  <= w_shadow_nxt;
          r_frame_err   <= w_shadow_err_nxt;
          r_frame_valid <= 1'b1;
        end
      end else if (r_frame_valid && frame_ready) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  assign frame_data  = r_frame_data;
  assign frame_err   = r_frame_err;
  assign frame_valid = r_frame_valid;
  assign overrun     = r_overrun;

endmodule

`default_nettype wire
